// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: message/control from the source and
// the multiplexed anode/segment drive toward the board pins.
interface seg_scan_ctrl_if;
  logic        en;
  logic        scroll_en;
  logic        cw;
  logic [55:0] msg;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [2:0]  sel;
  logic        frame_tick;

  modport master (
    output en, scroll_en, cw, msg,
    input  an, sseg, sel, frame_tick
  );

  modport slave (
    input  en, scroll_en, cw, msg,
    output an, sseg, sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Refresh/scroll controller for a 4-digit active-low multiplexed 7-seg display:
// shows a rotating 4-entry window of an 8-entry message with per-digit blanking.
module seg_scan_ctrl #(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int SCROLL_DIV = 100
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int ON_CYC = CLK_DIV - BLANK_CYC;
  localparam int CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        state, state_n;
  logic [1:0]    digit, digit_n;
  logic [CW-1:0] cyc_cnt, cyc_cnt_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [2:0]    ofs, ofs_n;
  logic [55:0]   msg_q, msg_q_n;
  logic [2:0]    idx;
  logic          frame_end;

  assign idx       = ofs + {1'b0, digit};
  assign frame_end = (state == ON) && (digit == 2'd3) && (cyc_cnt == ON_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digit     <= '0;
      cyc_cnt   <= '0;
      frame_cnt <= '0;
      ofs       <= '0;
      msg_q     <= '0;
    end else begin
      state     <= state_n;
      digit     <= digit_n;
      cyc_cnt   <= cyc_cnt_n;
      frame_cnt <= frame_cnt_n;
      ofs       <= ofs_n;
      msg_q     <= msg_q_n;
    end
  end

  always_comb begin
    state_n     = state;
    digit_n     = digit;
    cyc_cnt_n   = cyc_cnt;
    frame_cnt_n = frame_cnt;
    ofs_n       = ofs;
    msg_q_n     = msg_q;
    unique case (state)
      IDLE: begin
        if (bus.en) begin
          state_n   = BLANK;
          digit_n   = '0;
          cyc_cnt_n = '0;
          msg_q_n   = bus.msg;
        end
      end
      BLANK: begin
        if (!bus.en) begin
          state_n   = IDLE;
          digit_n   = '0;
          cyc_cnt_n = '0;
        end else if (cyc_cnt == BLANK_LAST) begin
          state_n   = ON;
          cyc_cnt_n = '0;
        end else begin
          cyc_cnt_n = cyc_cnt + CW'(1);
        end
      end
      ON: begin
        // End of frame outranks en=0 so the tick and scroll bookkeeping complete.
        if (frame_end) begin
          state_n   = bus.en ? BLANK : IDLE;
          digit_n   = '0;
          cyc_cnt_n = '0;
          msg_q_n   = bus.msg;
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt_n = '0;
            if (bus.scroll_en)
              ofs_n = bus.cw ? ofs + 3'd1 : ofs - 3'd1;
          end else begin
            frame_cnt_n = frame_cnt + FW'(1);
          end
        end else if (!bus.en) begin
          state_n   = IDLE;
          digit_n   = '0;
          cyc_cnt_n = '0;
        end else if (cyc_cnt == ON_LAST) begin
          state_n   = BLANK;
          digit_n   = digit + 2'd1;
          cyc_cnt_n = '0;
        end else begin
          cyc_cnt_n = cyc_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.an         = '1;
    bus.sseg       = '1;
    bus.sel        = '0;
    bus.frame_tick = frame_end;
    if (state != IDLE)
      bus.sel = idx;
    if (state == ON) begin
      bus.an[digit] = 1'b0;
      bus.sseg      = msg_q[int'(idx) * 7 +: 7];
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues the expected digit slots,
// a negedge monitor pops one per ON phase and checks drive, timing and ticks.
module tb_seg_scan_ctrl;
  localparam int CLK_DIV    = 8;
  localparam int BLANK_CYC  = 2;
  localparam int SCROLL_DIV = 3;
  localparam int ON_LEN     = CLK_DIV - BLANK_CYC;

  logic clk = 1'b0;
  logic rst;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC),
    .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sseg;
    logic [2:0] sel;
    int         blank;
    bit         len_chk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          ticks = 0;
  int          on_len = 0;
  int          blank_run = 0;
  bit          cur_len_chk = 1'b0;
  logic [3:0]  prev_an = 4'hF;
  logic [55:0] msg0, msg2;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int ofs, input logic [55:0] m, input int first_blank,
                            input int ndig, input bit last_len);
    exp_t e;
    for (int d = 0; d < ndig; d++) begin
      int idx;
      idx       = (ofs + d) % 8;
      e.an      = 4'hF;
      e.an[d]   = 1'b0;
      e.sseg    = m[idx*7 +: 7];
      e.sel     = 3'(idx);
      e.blank   = (d == 0) ? first_blank : BLANK_CYC;
      e.len_chk = (d == ndig - 1) ? last_len : 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 200);
    chk(tag, int'(bus.frame_tick), 1);
  endtask

  task automatic wait_an(input logic [3:0] v, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.an != v && n < 200);
    chk(tag, int'(bus.an), int'(v));
  endtask

  // Monitor: one queued slot per ON phase; blank run length counted since en/rst allowed it.
  always @(negedge clk) begin
    if (bus.an == 4'hF) begin
      if (prev_an != 4'hF && cur_len_chk)
        chk("on_len", on_len, ON_LEN);
      blank_run = (rst || !bus.en) ? 0 : blank_run + 1;
    end else begin
      if (prev_an == 4'hF) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_on", int'(bus.an), 15);
          cur_len_chk = 1'b0;
        end else begin
          mon_e = exp_q.pop_front();
          chk("slot_an", int'(bus.an), int'(mon_e.an));
          chk("slot_sseg", int'(bus.sseg), int'(mon_e.sseg));
          chk("slot_sel", int'(bus.sel), int'(mon_e.sel));
          chk("blank_len", blank_run, mon_e.blank);
          cur_len_chk = mon_e.len_chk;
        end
        on_len = 1;
      end else begin
        on_len++;
      end
      blank_run = 0;
    end
    if (bus.frame_tick) begin
      ticks++;
      chk("tick_an", int'(bus.an), 4'b0111);
      chk("tick_pos", on_len, ON_LEN);
    end
    prev_an = bus.an;
  end

  initial begin
    for (int k = 0; k < 8; k++) msg0[k*7 +: 7] = 7'h40 | 7'(k);
    msg2 = msg0;
    msg2[14 +: 7] = 7'h00;

    // Frames 1-3 static, 4-27 forward scroll every 3 frames, 28-30 back at ofs 0.
    for (int f = 1; f <= 30; f++)
      push_frame((f < 4) ? 0 : ((f - 4) / 3) % 8, msg0, (f == 1) ? 3 : BLANK_CYC, 4, 1'b1);
    push_frame(7, msg0, BLANK_CYC, 4, 1'b1);  // frame 31: reverse step
    push_frame(7, msg0, BLANK_CYC, 3, 1'b0);  // frame 32: en dropped in digit 2
    push_frame(7, msg0, 3, 1, 1'b0);          // re-enable, rst during digit 0
    push_frame(0, msg0, 3, 4, 1'b1);          // after reset: ofs back to 0
    push_frame(0, msg2, BLANK_CYC, 4, 1'b1);  // new message only from next frame

    rst = 1'b1;
    bus.en = 1'b1;
    bus.scroll_en = 1'b0;
    bus.cw = 1'b1;
    bus.msg = msg0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", int'(bus.an), 4'hF);
      chk("rst_sseg", int'(bus.sseg), 7'h7F);
      chk("rst_sel", int'(bus.sel), 0);
      chk("rst_tick", int'(bus.frame_tick), 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    for (int f = 1; f <= 31; f++) begin
      wait_tick("frame_tick");
      @(posedge clk); #1;
      if (f == 3) bus.scroll_en = 1'b1;
      if (f == 28) bus.cw = 1'b0;
      if (f == 31) bus.scroll_en = 1'b0;
    end

    wait_an(4'b1011, "f32_d2_on");
    @(posedge clk); #1 bus.en = 1'b0;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("off_an", int'(bus.an), 4'hF);
      chk("off_sseg", int'(bus.sseg), 7'h7F);
      chk("off_tick", int'(bus.frame_tick), 0);
    end
    @(posedge clk); #1 bus.en = 1'b1;

    wait_an(4'b1110, "reen_d0_on");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_an", int'(bus.an), 4'hF);
    chk("midrst_sseg", int'(bus.sseg), 7'h7F);
    chk("midrst_sel", int'(bus.sel), 0);
    chk("midrst_tick", int'(bus.frame_tick), 0);
    @(posedge clk); #1 rst = 1'b0;

    wait_an(4'b1101, "r1_d1_on");
    @(posedge clk); #1 bus.msg = msg2;
    wait_tick("r1_tick");
    wait_tick("r2_tick");
    @(posedge clk); #1 bus.en = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_left", exp_q.size(), 0);
    chk("tick_count", ticks, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
